seven_seg_mux: RTL and testbench

Parametrised, time-multiplexed driver for common-anode seven-segment displays with any digit count. It latches a packed hex value through a load/pending handshake and presents it tear-free by committing only at frame boundaries. It supports per-digit decimal points, leading-zero blanking and per-digit blink. It sits between the clock/status datapath and the board's anode/segment pins, replacing the fixed four-digit, free-running scanner.

---
 rtl/seven_seg_mux.sv | 162 ++++++++++++++++
 tb/tb_seven_seg_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed common-anode seven-segment driver
// with tear-free frame-boundary commit, decimal points, LZ blanking, blink.
module seven_seg_mux #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  load,
    output logic                  pending,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;

    logic [4*DIGITS-1:0]   st_value;
    logic [DIGITS-1:0]     st_dp;
    logic                  st_blz;
    logic [DIGITS-1:0]     st_bmask;

    logic [4*DIGITS-1:0]   sh_value;
    logic [DIGITS-1:0]     sh_dp;
    logic                  sh_blz;
    logic [DIGITS-1:0]     sh_bmask;

    logic                  tick;
    logic                  boundary;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     lz_vec;
    logic                  blank;
    logic [DIGITS-1:0]     an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick     = (presc == PMAX);
    assign boundary = tick && (idx == IMAX);

    // lz_vec[i] set when nibbles i..DIGITS-1 are all zero; digit 0 exempt
    always_comb begin
        logic run;
        run    = 1'b1;
        lz_vec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run       = run && (sh_value[4*i +: 4] == 4'h0);
            lz_vec[i] = run && (i != 0);
        end
    end

    always_comb begin
        nib   = sh_value[{idx, 2'b00} +: 4];
        blank = (sh_blz && lz_vec[idx]) ||
                (sh_bmask[idx] && blink_phase);
        an_d  = '1;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(DIGITS'(1) << idx);
            seg_d = decode(nib);
            dp_d  = ~sh_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            st_value    <= '0;
            st_dp       <= '0;
            st_blz      <= 1'b0;
            st_bmask    <= '0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_blz      <= 1'b0;
            sh_bmask    <= '0;
            pending     <= 1'b0;
            an          <= '1;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= (idx == IMAX) ? '0 : idx + 1'b1;

            if (boundary) begin
                if (frame_cnt == FMAX) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // shadow takes pre-edge staging, so a coincident load stays pending
            if (boundary && pending) begin
                sh_value <= st_value;
                sh_dp    <= st_dp;
                sh_blz   <= st_blz;
                sh_bmask <= st_bmask;
            end

            if (load) begin
                st_value <= value;
                st_dp    <= dp_in;
                st_blz   <= blank_lz;
                st_bmask <= blink_mask;
            end

            if (load)
                pending <= 1'b1;
            else if (boundary)
                pending <= 1'b0;

            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux with DIGITS=4, REFRESH_DIV=4,
// BLINK_FRAMES=2; expected patterns are hand-computed per frame.
module tb_seven_seg_mux;

    localparam int D = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    logic          clk = 0;
    logic          reset;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [3:0]    blink_mask;
    logic          load;
    logic          pending;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    seven_seg_mux #(
        .DIGITS(D),
        .REFRESH_DIV(4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .blink_mask(blink_mask),
        .load(load),
        .pending(pending),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // segs packed {d3,d2,d1,d0}; call when the next cycle starts digit 0
    task automatic check_frame(input string tag,
                               input logic [27:0] segs,
                               input logic [3:0] blk,
                               input logic [3:0] dpl);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int d = 0; d < D; d++) begin
            ea = blk[d] ? 4'hF : ~(4'b0001 << d);
            es = blk[d] ? SB : segs[7*d +: 7];
            ed = blk[d] ? 1'b1 : ~dpl[d];
            for (int k = 0; k < 4; k++) begin
                step();
                chk({tag, "_an"}, 32'(an), 32'(ea));
                chk({tag, "_seg"}, 32'(seg), 32'(es));
                chk({tag, "_dp"}, 32'(dp), 32'(ed));
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv,
                           input logic blz, input logic [3:0] bm);
        value      = v;
        dp_in      = dpv;
        blank_lz   = blz;
        blink_mask = bm;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        value      = '0;
        dp_in      = '0;
        blank_lz   = 1'b0;
        blink_mask = '0;
        load       = 1'b0;
        step();
        step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'(SB));
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_pend", 32'(pending), 32'd0);
        reset = 1'b0;
        cyc   = 0;

        // idle: zeros scanned, 4 cycles per digit
        check_frame("idle", {S0, S0, S0, S0}, 4'b0000, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("idle_an", 32'(an), 32'hE);
            chk("idle_seg", 32'(seg), 32'(S0));
            chk("idle_pend", 32'(pending), 32'd0);
        end

        // mid-frame load, commits at edge 32
        do_load(16'h12AF, 4'b0100, 1'b0, 4'b0000);
        chk("ld_pend1", 32'(pending), 32'd1);
        run_to(31);
        chk("ld_pend31", 32'(pending), 32'd1);
        step();
        chk("ld_pend32", 32'(pending), 32'd0);
        chk("ld_old_an", 32'(an), 32'h7);
        chk("ld_old_seg", 32'(seg), 32'(S0));
        check_frame("hex", {S1, S2, SA, SF}, 4'b0000, 4'b0100);

        // leading-zero blanking
        do_load(16'h0070, 4'b0000, 1'b1, 4'b0000);
        chk("lz_pend", 32'(pending), 32'd1);
        run_to(64);
        chk("lz_pend64", 32'(pending), 32'd0);
        check_frame("lz", {S0, S0, S7, S0}, 4'b1100, 4'b0000);

        // blink digit 0: phase=1 after edges 96, 160; 0 after 128
        do_load(16'h0000, 4'b0000, 1'b0, 4'b0001);
        run_to(96);
        check_frame("blk_h0", {S0, S0, S0, S0}, 4'b0001, 4'b0000);
        check_frame("blk_h1", {S0, S0, S0, S0}, 4'b0001, 4'b0000);
        check_frame("blk_v0", {S0, S0, S0, S0}, 4'b0000, 4'b0000);
        check_frame("blk_v1", {S0, S0, S0, S0}, 4'b0000, 4'b0000);
        check_frame("blk_h2", {S0, S0, S0, S0}, 4'b0001, 4'b0000);

        // load coincident with the boundary at edge 192
        do_load(16'h1111, 4'b0000, 1'b0, 4'b0000);
        run_to(191);
        do_load(16'h2222, 4'b0000, 1'b0, 4'b0000);
        chk("co_pend192", 32'(pending), 32'd1);
        check_frame("co_1111", {S1, S1, S1, S1}, 4'b0000, 4'b0000);
        chk("co_pend208", 32'(pending), 32'd0);
        check_frame("co_2222", {S2, S2, S2, S2}, 4'b0000, 4'b0000);

        // reset while pending at index 2
        do_load(16'h3333, 4'b1111, 1'b0, 4'b0000);
        run_to(233);
        chk("mr_pend_pre", 32'(pending), 32'd1);
        chk("mr_an_pre", 32'(an), 32'hB);
        reset = 1'b1;
        step();
        chk("mr_an", 32'(an), 32'hF);
        chk("mr_seg", 32'(seg), 32'(SB));
        chk("mr_pend", 32'(pending), 32'd0);
        reset = 1'b0;
        cyc   = 0;
        check_frame("mr_zero", {S0, S0, S0, S0}, 4'b0000, 4'b0000);
        chk("mr_pend_post", 32'(pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
